button_event_arbiter: RTL and testbench

BUTTON_EVENT_ARBITER -- requirements
Module: button_event_arbiter

---
 rtl/button_event_arbiter_pkg.sv | 53 +++++
 rtl/button_event_arbiter_if.sv | 25 ++
 rtl/button_event_arbiter_btn_tracker.sv | 109 ++++++++++
 rtl/button_event_arbiter.sv | 110 +++++++++++
 tb/tb_button_event_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/button_event_arbiter_pkg.sv
// btn_evt_pkg: event and button-state encodings shared by the button event arbiter.
// BTN_AUTOREPEAT_EN: when defined, the REPEAT event type and its pending bit exist.
package btn_evt_pkg;

  typedef enum logic [1:0] {
    PRESS   = 2'd0,
    RELEASE = 2'd1,
    LONG    = 2'd2,
    REPEAT  = 2'd3
  } evt_type_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HELD      = 2'd1,
    LONG_HELD = 2'd2
  } btn_state_t;

  // REPEAT holds the highest encoding, so dropping it just trims the top pending bit.
`ifdef BTN_AUTOREPEAT_EN
  localparam int NUM_TYPES = 4;
`else
  localparam int NUM_TYPES = 3;
`endif

  // Type priority inside one button: PRESS > LONG > REPEAT > RELEASE.
  function automatic evt_type_t pick_type(input logic [NUM_TYPES-1:0] pend);
    evt_type_t t;
    if (pend[PRESS])       t = PRESS;
    else if (pend[LONG])   t = LONG;
`ifdef BTN_AUTOREPEAT_EN
    else if (pend[REPEAT]) t = REPEAT;
`endif
    else                   t = RELEASE;
    return t;
  endfunction

  // One-hot pending-bit mask for an event type.
  function automatic logic [NUM_TYPES-1:0] type_mask(input evt_type_t t);
    logic [NUM_TYPES-1:0] m;
    m = '0;
    case (t)
      PRESS:   m[PRESS]   = 1'b1;
      RELEASE: m[RELEASE] = 1'b1;
      LONG:    m[LONG]    = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
      REPEAT:  m[REPEAT]  = 1'b1;
`endif
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/button_event_arbiter_if.sv
// button_event_arbiter_if: valid/ready event channel; the arbiter is master, the consumer slave.
interface button_event_arbiter_if #(
  parameter int NUM_BTNS = 4
);
  localparam int BTN_W = $clog2(NUM_BTNS);

  logic             event_valid_out;
  logic             event_ready_in;
  logic [BTN_W-1:0] event_btn_out;
  logic [1:0]       event_type_out;

  modport master (
    output event_valid_out,
    output event_btn_out,
    output event_type_out,
    input  event_ready_in
  );

  modport slave (
    input  event_valid_out,
    input  event_btn_out,
    input  event_type_out,
    output event_ready_in
  );
endinterface

// File: rtl/button_event_arbiter_btn_tracker.sv
// btn_tracker: one button's IDLE/HELD/LONG_HELD FSM, hold/repeat counters and pending bits.
// BTN_AUTOREPEAT_EN: when defined, LONG_HELD raises REPEAT every REPEAT_CYCLES cycles.
module btn_tracker
  import btn_evt_pkg::*;
#(
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 i_level,
  input  logic [NUM_TYPES-1:0] i_clr,
  output logic [NUM_TYPES-1:0] o_pend,
  output logic                 o_ovf
);

  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

  if (LONG_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_cycles
    $error("btn_tracker: LONG_CYCLES and REPEAT_CYCLES must be at least 1");
  end

  btn_state_t           r_state;
  btn_state_t           w_state_nxt;
  logic [HOLD_W-1:0]    r_hold_cnt;
  logic [NUM_TYPES-1:0] r_pend;
  logic [NUM_TYPES-1:0] w_set;

`ifdef BTN_AUTOREPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
  logic [REP_W-1:0] r_rep_cnt;
`endif

  // FSM state register.
  // NOTE: sequential state uses <= so every flop samples pre-edge values; = here would make results depend on block order.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and the events raised by each transition.
  // NOTE: every signal gets a default first, so no path leaves it unassigned and infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_set       = '0;
    case (r_state)
      IDLE: begin
        if (i_level) begin
          w_state_nxt = HELD;
          w_set[PRESS] = 1'b1;
        end
      end
      HELD: begin
        if (!i_level) begin
          w_state_nxt = IDLE;
          w_set[RELEASE] = 1'b1;
        end else if (r_hold_cnt == HOLD_LAST) begin
          w_state_nxt = LONG_HELD;
          w_set[LONG] = 1'b1;
        end
      end
      LONG_HELD: begin
        if (!i_level) begin
          w_state_nxt = IDLE;
          w_set[RELEASE] = 1'b1;
        end
`ifdef BTN_AUTOREPEAT_EN
        else if (r_rep_cnt == REP_LAST) begin
          w_set[REPEAT] = 1'b1;
        end
`endif
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Hold counter: starts at zero on entry to HELD and advances every cycle spent in HELD.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)                                        r_hold_cnt <= '0;
    else if (r_state == HELD && w_state_nxt == HELD)   r_hold_cnt <= r_hold_cnt + 1'b1;
    else                                               r_hold_cnt <= '0;
  end

`ifdef BTN_AUTOREPEAT_EN
  // Repeat counter: wraps every REPEAT_CYCLES while LONG_HELD, cleared on entry and exit.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)
      r_rep_cnt <= '0;
    else if (r_state == LONG_HELD && w_state_nxt == LONG_HELD)
      r_rep_cnt <= (r_rep_cnt == REP_LAST) ? '0 : r_rep_cnt + 1'b1;
    else
      r_rep_cnt <= '0;
  end
`endif

  // Pending bits: a grant clears its bit, a new event sets it; a same-cycle set wins over the clear.
  // NOTE: pending bits are live handshake state, so they are reset explicitly like every other flop here.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) r_pend <= '0;
    else        r_pend <= (r_pend & ~i_clr) | w_set;
  end

  // An event whose bit is still pending and not being granted this cycle is dropped.
  assign o_ovf  = |(w_set & r_pend & ~i_clr);
  assign o_pend = r_pend;

endmodule

// File: rtl/button_event_arbiter.sv
// button_event_arbiter: per-button event trackers feeding a round-robin arbiter and one
// valid/ready output register. BTN_AUTOREPEAT_EN enables REPEAT events in the trackers.
module button_event_arbiter
  import btn_evt_pkg::*;
#(
  parameter int NUM_BTNS      = 4,
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic [NUM_BTNS-1:0]    btn_clean_in,
  button_event_arbiter_if.master evt,
  output logic                   overflow_out
);

  localparam int BTN_W = $clog2(NUM_BTNS);

  if (NUM_BTNS < 2 || NUM_BTNS > 16) begin : g_bad_num_btns
    $error("button_event_arbiter: NUM_BTNS must be in 2..16");
  end

  logic [NUM_BTNS-1:0][NUM_TYPES-1:0] w_pend;
  logic [NUM_BTNS-1:0][NUM_TYPES-1:0] w_clr;
  logic [NUM_BTNS-1:0]                w_ovf;
  logic [NUM_BTNS-1:0]                w_any;

  logic             r_valid;
  logic [BTN_W-1:0] r_btn;
  evt_type_t        r_type;
  logic [BTN_W-1:0] r_rr_ptr;
  logic             r_overflow;

  logic             w_found;
  logic [BTN_W-1:0] w_sel;
  evt_type_t        w_sel_type;
  logic             w_load;
  logic             w_grant;
  logic [BTN_W-1:0] w_rr_nxt;

  for (genvar g = 0; g < NUM_BTNS; g++) begin : g_btn
    btn_tracker #(
      .LONG_CYCLES  (LONG_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_tracker (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .i_level(btn_clean_in[g]),
      .i_clr  (w_clr[g]),
      .o_pend (w_pend[g]),
      .o_ovf  (w_ovf[g])
    );
    assign w_any[g] = |w_pend[g];
  end

  // Round-robin search: first button with anything pending, starting at r_rr_ptr.
  always_comb begin
    logic [BTN_W-1:0] cand;
    w_found = 1'b0;
    w_sel   = '0;
    cand    = '0;
    for (int k = 0; k < NUM_BTNS; k++) begin
      cand = BTN_W'((int'(r_rr_ptr) + k) % NUM_BTNS);
      if (!w_found && w_any[cand]) begin
        w_found = 1'b1;
        w_sel   = cand;
      end
    end
  end

  assign w_sel_type = pick_type(w_pend[w_sel]);
  assign w_load     = !r_valid || evt.event_ready_in;
  assign w_grant    = w_load && w_found;
  assign w_rr_nxt   = (int'(w_sel) == NUM_BTNS - 1) ? '0 : w_sel + 1'b1;

  // Clear only the granted bit of the granted button.
  always_comb begin
    w_clr = '0;
    if (w_grant) w_clr[w_sel] = type_mask(w_sel_type);
  end

  // Output register: loads when empty or accepted; holds steady while stalled.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_valid  <= 1'b0;
      r_btn    <= '0;
      r_type   <= PRESS;
      r_rr_ptr <= '0;
    end else if (w_load) begin
      r_valid <= w_found;
      if (w_found) begin
        r_btn    <= w_sel;
        r_type   <= w_sel_type;
        r_rr_ptr <= w_rr_nxt;
      end
    end
  end

  // Sticky overflow: any dropped event keeps the flag up until reset.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) r_overflow <= 1'b0;
    else        r_overflow <= r_overflow | (|w_ovf);
  end

  assign evt.event_valid_out = r_valid;
  assign evt.event_btn_out   = r_btn;
  assign evt.event_type_out  = r_type;
  assign overflow_out        = r_overflow;

endmodule

// File: tb/tb_button_event_arbiter.sv
// tb_button_event_arbiter: directed scenarios plus randomized button/ready traffic, every cycle
// compared against a behavioural model built from hold ages and per-button pending sets.
module tb_button_event_arbiter;

  localparam int N = 4;
  localparam int L = 20;
  localparam int R = 5;
  localparam int T_PRESS   = 0;
  localparam int T_RELEASE = 1;
  localparam int T_LONG    = 2;
  localparam int T_REPEAT  = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] btn;
  logic         ovf;

  button_event_arbiter_if #(.NUM_BTNS(N)) evt_if ();

  button_event_arbiter #(
    .NUM_BTNS     (N),
    .LONG_CYCLES  (L),
    .REPEAT_CYCLES(R)
  ) dut (
    .clk_in      (clk),
    .rst_in      (rst),
    .btn_clean_in(btn),
    .evt         (evt_if),
    .overflow_out(ovf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model state.
  bit m_pend [N][4];
  bit m_held [N];
  int m_age  [N];
  bit m_valid;
  int m_btn;
  int m_type;
  bit m_ovf;
  int m_rr;
  int prio [4] = '{T_PRESS, T_LONG, T_REPEAT, T_RELEASE};

  typedef struct {
    int cyc;
    int btn;
    int typ;
  } ev_t;
  ev_t ev_q[$];
  bit  prev_valid;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic model_reset();
    for (int b = 0; b < N; b++) begin
      for (int t = 0; t < 4; t++) m_pend[b][t] = 1'b0;
      m_held[b] = 1'b0;
      m_age[b]  = 0;
    end
    m_valid = 1'b0;
    m_btn   = 0;
    m_type  = 0;
    m_ovf   = 1'b0;
    m_rr    = 0;
  endtask

  task automatic raise(input int b, input int t);
    if (m_pend[b][t]) m_ovf = 1'b1;
    else              m_pend[b][t] = 1'b1;
  endtask

  // One clock edge of the model: grant from the old pending sets, then record new events.
  task automatic model_edge(input logic [N-1:0] lv, input logic rdy);
    bit found;
    int gb, gt, b;
    found = 1'b0;
    gb = 0;
    gt = 0;
    if (!m_valid || rdy) begin
      for (int k = 0; k < N; k++) begin
        b = (m_rr + k) % N;
        for (int p = 0; p < 4; p++) begin
          if (!found && m_pend[b][prio[p]]) begin
            found = 1'b1;
            gb = b;
            gt = prio[p];
          end
        end
      end
      m_valid = found;
      if (found) begin
        m_btn = gb;
        m_type = gt;
        m_pend[gb][gt] = 1'b0;
        m_rr = (gb + 1) % N;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!m_held[i] && lv[i]) begin
        raise(i, T_PRESS);
        m_held[i] = 1'b1;
        m_age[i]  = 0;
      end else if (m_held[i] && !lv[i]) begin
        raise(i, T_RELEASE);
        m_held[i] = 1'b0;
      end else if (m_held[i]) begin
        m_age[i]++;
        if (m_age[i] == L) raise(i, T_LONG);
`ifdef BTN_AUTOREPEAT_EN
        else if (m_age[i] > L && (m_age[i] - L) % R == 0) raise(i, T_REPEAT);
`endif
      end
    end
  endtask

  // Advance one cycle, update the model and compare every output.
  task automatic step();
    logic [N-1:0] lv;
    logic         rdy;
    lv  = btn;
    rdy = evt_if.event_ready_in;
    @(posedge clk);
    #1;
    cyc++;
    if (rst) model_reset();
    else     model_edge(lv, rdy);
    check("valid", evt_if.event_valid_out, m_valid);
    if (m_valid) begin
      check("btn", evt_if.event_btn_out, m_btn);
      check("type", evt_if.event_type_out, m_type);
    end
    check("overflow", ovf, m_ovf);
    if (evt_if.event_valid_out === 1'b1 && (!prev_valid || rdy === 1'b1))
      ev_q.push_back('{cyc, int'(evt_if.event_btn_out), int'(evt_if.event_type_out)});
    prev_valid = evt_if.event_valid_out;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int rel_cyc;
    rst = 1'b1;
    btn = '0;
    evt_if.event_ready_in = 1'b1;
    prev_valid = 1'b0;
    model_reset();
    repeat (3) step();
    check("rst_valid", evt_if.event_valid_out, 0);
    check("rst_btn", evt_if.event_btn_out, 0);
    check("rst_type", evt_if.event_type_out, 0);
    check("rst_ovf", ovf, 0);
    rst = 1'b0;
    repeat (5) step();

    // Short press on button 2: PRESS two cycles after the edge, RELEASE likewise, no LONG.
    ev_q.delete();
    btn[2] = 1'b1;
    step();
    check("press_lat1_valid", evt_if.event_valid_out, 0);
    step();
    check("press_lat2_valid", evt_if.event_valid_out, 1);
    check("press_lat2_btn", evt_if.event_btn_out, 2);
    check("press_lat2_type", evt_if.event_type_out, T_PRESS);
    repeat (3) step();
    btn[2] = 1'b0;
    repeat (2) step();
    check("rel_valid", evt_if.event_valid_out, 1);
    check("rel_btn", evt_if.event_btn_out, 2);
    check("rel_type", evt_if.event_type_out, T_RELEASE);
    repeat (4) step();
    check("short_count", ev_q.size(), 2);

    // Long hold on button 1.
    ev_q.delete();
    btn[1] = 1'b1;
    repeat (32) step();
    btn[1] = 1'b0;
    repeat (4) step();
`ifdef BTN_AUTOREPEAT_EN
    check("long_count", ev_q.size(), 5);
    if (ev_q.size() == 5) begin
      check("long_t0", ev_q[0].typ, T_PRESS);
      check("long_t1", ev_q[1].typ, T_LONG);
      check("long_t2", ev_q[2].typ, T_REPEAT);
      check("long_t3", ev_q[3].typ, T_REPEAT);
      check("long_t4", ev_q[4].typ, T_RELEASE);
      check("long_dt", ev_q[1].cyc - ev_q[0].cyc, 20);
      check("rep1_dt", ev_q[2].cyc - ev_q[1].cyc, 5);
      check("rep2_dt", ev_q[3].cyc - ev_q[1].cyc, 10);
    end
`else
    check("long_count", ev_q.size(), 3);
    if (ev_q.size() == 3) begin
      check("long_t0", ev_q[0].typ, T_PRESS);
      check("long_t1", ev_q[1].typ, T_LONG);
      check("long_t2", ev_q[2].typ, T_RELEASE);
      check("long_dt", ev_q[1].cyc - ev_q[0].cyc, 20);
    end
`endif
    foreach (ev_q[i]) check("long_btn", ev_q[i].btn, 1);

    // Tap button 0 so the last grant leaves rr_ptr at 1, then press 0,1,3 together.
    btn[0] = 1'b1;
    repeat (3) step();
    btn[0] = 1'b0;
    repeat (3) step();
    ev_q.delete();
    btn = 4'b1011;
    repeat (5) step();
    check("rr_count", ev_q.size(), 3);
    if (ev_q.size() == 3) begin
      check("rr_first", ev_q[0].btn, 1);
      check("rr_second", ev_q[1].btn, 3);
      check("rr_third", ev_q[2].btn, 0);
      check("rr_b2b_a", ev_q[1].cyc - ev_q[0].cyc, 1);
      check("rr_b2b_b", ev_q[2].cyc - ev_q[1].cyc, 1);
      foreach (ev_q[i]) check("rr_type", ev_q[i].typ, T_PRESS);
    end
    btn = '0;
    repeat (6) step();

    // Stalled consumer: output holds, repeated events on button 0 overflow.
    evt_if.event_ready_in = 1'b0;
    btn[0] = 1'b1;
    repeat (3) step();
    btn[0] = 1'b0;
    repeat (2) step();
    btn[0] = 1'b1;
    repeat (2) step();
    btn[0] = 1'b0;
    repeat (2) step();
    btn[0] = 1'b1;
    repeat (2) step();
    check("stall_valid", evt_if.event_valid_out, 1);
    check("stall_btn", evt_if.event_btn_out, 0);
    check("stall_type", evt_if.event_type_out, T_PRESS);
    check("stall_ovf", ovf, 1);
    evt_if.event_ready_in = 1'b1;
    repeat (6) step();
    btn[0] = 1'b0;
    repeat (6) step();
    check("ovf_sticky", ovf, 1);

    // Reset in the middle of a stalled handshake with button 3 held.
    evt_if.event_ready_in = 1'b0;
    btn[3] = 1'b1;
    repeat (3) step();
    check("pre_rst_valid", evt_if.event_valid_out, 1);
    check("pre_rst_btn", evt_if.event_btn_out, 3);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", evt_if.event_valid_out, 0);
    check("async_rst_btn", evt_if.event_btn_out, 0);
    check("async_rst_type", evt_if.event_type_out, 0);
    check("async_rst_ovf", ovf, 0);
    repeat (2) step();
    rst = 1'b0;
    evt_if.event_ready_in = 1'b1;
    rel_cyc = cyc;
    ev_q.delete();
    repeat (4) step();
    check("post_rst_count", ev_q.size(), 1);
    if (ev_q.size() == 1) begin
      check("post_rst_lat", ev_q[0].cyc - rel_cyc, 2);
      check("post_rst_btn", ev_q[0].btn, 3);
      check("post_rst_type", ev_q[0].typ, T_PRESS);
    end
    btn = '0;
    repeat (4) step();

    // Random button traffic with a randomly stalling consumer and rare resets.
    for (int i = 0; i < 4000; i++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 23) == 0) btn[b] = ~btn[b];
      evt_if.event_ready_in = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 599) == 0);
      step();
    end
    rst = 1'b0;
    repeat (2) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
